// File: rtl/top_filter.sv
// Sample-triggered fixed-coefficient FIR with one shared MAC; TOP_FILTER_SAT_EN selects clamping over wrap.
// Latency: data_out updates NUM_TAPS+1 clocks after the trigger edge clock, held otherwise.
// Backpressure: none; trigger edges arriving while busy are dropped.
module top_filter #(
    parameter int COEF_SIZE = 32,
    parameter int DATA_SIZE = 24,
    parameter int NUM_TAPS  = 8,
    parameter int COEF_FRAC = 30,
    parameter logic [NUM_TAPS*COEF_SIZE-1:0] COEFS =
        {{((NUM_TAPS-2)*COEF_SIZE){1'b0}}, 32'hE000_0000, 32'h2000_0000}
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_trig,
    input  logic [DATA_SIZE-1:0] data_in,
    output logic [DATA_SIZE-1:0] data_out
);

    localparam int PW = DATA_SIZE + COEF_SIZE;
    localparam int IW = $clog2(NUM_TAPS);
    localparam int AW = PW + IW;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_TAPS - 1);
    localparam logic signed [AW-1:0] RND_C =
        {{(AW-COEF_FRAC){1'b0}}, 1'b1, {(COEF_FRAC-1){1'b0}}};
    localparam logic signed [AW-1:0] MAX_C =
        {{(AW-DATA_SIZE+1){1'b0}}, {(DATA_SIZE-1){1'b1}}};
    localparam logic signed [AW-1:0] MIN_C =
        {{(AW-DATA_SIZE+1){1'b1}}, {(DATA_SIZE-1){1'b0}}};
    localparam logic [DATA_SIZE-1:0] MAX_D = {1'b0, {(DATA_SIZE-1){1'b1}}};
    localparam logic [DATA_SIZE-1:0] MIN_D = {1'b1, {(DATA_SIZE-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                       state_q, state_d;
    logic                         trig_q, trig_d;
    logic signed [DATA_SIZE-1:0]  x_q [NUM_TAPS];
    logic signed [DATA_SIZE-1:0]  x_d [NUM_TAPS];
    logic signed [AW-1:0]         acc_q, acc_d;
    logic [IW-1:0]                idx_q, idx_d;
    logic [DATA_SIZE-1:0]         data_out_q, data_out_d;

    logic                         trig_edge;
    logic signed [COEF_SIZE-1:0]  coef;
    logic signed [PW-1:0]         prod;
    logic signed [AW-1:0]         prod_ext;
    logic signed [AW-1:0]         rnd_sum;
    logic signed [AW-1:0]         rnd_val;
    logic [DATA_SIZE-1:0]         sat_val;

    assign trig_edge = sample_trig & ~trig_q;
    assign coef      = COEFS[idx_q*COEF_SIZE +: COEF_SIZE];
    assign prod      = coef * x_q[idx_q];
    assign prod_ext  = {{(AW-PW){prod[PW-1]}}, prod};
    assign data_out  = data_out_q;

    // Round half toward +inf, then drop the coefficient fraction.
    always_comb begin
        rnd_sum = acc_q + RND_C;
        rnd_val = rnd_sum >>> COEF_FRAC;
`ifdef TOP_FILTER_SAT_EN
        if (rnd_val > MAX_C) begin
            sat_val = MAX_D;
        end else if (rnd_val < MIN_C) begin
            sat_val = MIN_D;
        end else begin
            sat_val = DATA_SIZE'(rnd_val);
        end
`else
        sat_val = DATA_SIZE'(rnd_val);
`endif
    end

    always_comb begin
        state_d    = state_q;
        trig_d     = sample_trig;
        x_d        = x_q;
        acc_d      = acc_q;
        idx_d      = idx_q;
        data_out_d = data_out_q;
        case (state_q)
            IDLE: begin
                if (trig_edge) begin
                    for (int k = 1; k < NUM_TAPS; k++) begin
                        x_d[k] = x_q[k-1];
                    end
                    x_d[0]  = data_in;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = acc_q + prod_ext;
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = OUT;
                end
            end
            OUT: begin
                data_out_d = sat_val;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            trig_q     <= 1'b0;
            acc_q      <= '0;
            idx_q      <= '0;
            data_out_q <= '0;
            for (int k = 0; k < NUM_TAPS; k++) begin
                x_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            trig_q     <= trig_d;
            acc_q      <= acc_d;
            idx_q      <= idx_d;
            data_out_q <= data_out_d;
            x_q        <= x_d;
        end
    end

endmodule

// File: tb/tb_top_filter.sv
// Directed and randomized bench for top_filter; expected outputs come from a
// sample-history model doing plain 64-bit convolution with the default coefficients.
`timescale 1ns/1ps
module tb_top_filter;

    localparam int NT = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_trig;
    logic [23:0] data_in;
    logic [23:0] data_out;

    int n_cmp = 0;
    int n_bad = 0;

    longint      hist [NT];
    longint      h    [NT];
    logic [23:0] exp_out;

    top_filter dut (
        .clk        (clk),
        .reset      (reset),
        .sample_trig(sample_trig),
        .data_in    (data_in),
        .data_out   (data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [23:0] model_out();
        longint acc;
        longint r;
        acc = 0;
        for (int k = 0; k < NT; k++) acc += h[k] * hist[k];
        r = (acc + 64'sd536870912) >>> 30;
`ifdef TOP_FILTER_SAT_EN
        if (r > 64'sd8388607) r = 64'sd8388607;
        else if (r < -64'sd8388608) r = -64'sd8388608;
`endif
        return r[23:0];
    endfunction

    task automatic model_push(input logic [23:0] d);
        for (int k = NT - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = longint'($signed(d));
        exp_out = model_out();
    endtask

    task automatic model_clear();
        for (int k = 0; k < NT; k++) hist[k] = 0;
        exp_out = 24'h000000;
    endtask

    // One trigger: trig high for `hold` clocks, optional spurious edge at cycle 4.
    task automatic send(input logic [23:0] d, input int hold, input bit spur, input string tag);
        logic [23:0] prev;
        prev        = exp_out;
        data_in     = d;
        sample_trig = 1'b1;
        @(posedge clk); #1;
        model_push(d);
        data_in     = 24'($urandom);
        sample_trig = (1 < hold);
        for (int c = 1; c <= NT; c++) begin
            @(posedge clk); #1;
            data_in     = 24'($urandom);
            sample_trig = ((c + 1) < hold) || (spur && (c + 1) == 4);
        end
        check({tag, "_held"}, data_out, prev);
        @(posedge clk); #1;
        check(tag, data_out, exp_out);
    endtask

    task automatic abort_mid_mac(input logic [23:0] d);
        data_in     = d;
        sample_trig = 1'b1;
        @(posedge clk); #1;
        sample_trig = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("abort_out", data_out, 24'h000000);
        model_clear();
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        for (int k = 0; k < NT; k++) h[k] = 0;
        h[0] = 64'sd536870912;
        h[1] = -64'sd536870912;
        model_clear();

        // Reset held while inputs churn; trig left high at release.
        reset       = 1'b1;
        sample_trig = 1'b0;
        data_in     = 24'h000000;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            data_in     = 24'($urandom);
            sample_trig = 1'($urandom_range(0, 1));
            if (i % 4 == 3) check("rst_hold", data_out, 24'h000000);
        end
        sample_trig = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        send(24'h123456, 1, 1'b0, "first_after_rst");

        // Impulse response
        send(24'h000000, 1, 1'b0, "flush0");
        send(24'h000000, 1, 1'b0, "flush1");
        send(24'h100000, 1, 1'b0, "imp0");  check("imp0_lit", data_out, 24'h080000);
        send(24'h000000, 1, 1'b0, "imp1");  check("imp1_lit", data_out, 24'hF80000);
        send(24'h000000, 1, 1'b0, "imp2");  check("imp2_lit", data_out, 24'h000000);
        send(24'h000000, 1, 1'b0, "imp3");  check("imp3_lit", data_out, 24'h000000);

        // DC rejection
        send(24'h200000, 1, 1'b0, "dc0");   check("dc0_lit", data_out, 24'h100000);
        for (int i = 0; i < 3; i++) begin
            send(24'h200000, 1, 1'b0, "dc_n");
            check("dc_lit", data_out, 24'h000000);
        end

        // Nyquist tone
        send(24'h400000, 1, 1'b0, "nyq_t0");
        send(24'hC00000, 1, 1'b0, "nyq_t1");
        for (int i = 0; i < 2; i++) begin
            send(24'h400000, 1, 1'b0, "nyq_p"); check("nyq_p_lit", data_out, 24'h400000);
            send(24'hC00000, 1, 1'b0, "nyq_n"); check("nyq_n_lit", data_out, 24'hC00000);
        end

        // Full-scale alternation: clamp vs wrap
        send(24'h7FFFFF, 1, 1'b0, "fs_t0");
        for (int i = 0; i < 2; i++) begin
            send(24'h800000, 1, 1'b0, "fs_n"); check("fs_n_lit", data_out, 24'h800001);
            send(24'h7FFFFF, 1, 1'b0, "fs_p");
`ifdef TOP_FILTER_SAT_EN
            check("fs_p_lit", data_out, 24'h7FFFFF);
`else
            check("fs_p_lit", data_out, 24'h800000);
`endif
        end

        // Long trigger plus an edge during MAC: one capture only
        send(24'h100000, 3, 1'b1, "hold3_spur");
        send(24'h000000, 1, 1'b0, "after_spur"); check("after_spur_lit", data_out, 24'hF80000);

        // Reset mid-computation, then impulse from a cleared line
        abort_mid_mac(24'h300000);
        send(24'h100000, 1, 1'b0, "post_abort0"); check("post_abort0_lit", data_out, 24'h080000);
        send(24'h000000, 1, 1'b0, "post_abort1"); check("post_abort1_lit", data_out, 24'hF80000);

        // Randomized samples and trigger shapes
        for (int i = 0; i < 24; i++) begin
            send(24'($urandom), $urandom_range(1, 3), 1'($urandom_range(0, 1)), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
